// File: rtl/maj_vote_filter_pkg.sv
// Shared defaults and in_bus indexing helper for the majority-vote filter.
package maj_vote_filter_pkg;

    localparam int DEF_N      = 3;
    localparam int DEF_W      = 4;
    localparam int DEF_STABLE = 3;
    localparam int DEF_CNT_W  = 8;

    // Flat in_bus position of replica r, channel c.
    function automatic int bit_idx(input int r, input int c, input int w);
        return r * w + c;
    endfunction

endpackage

// File: rtl/maj_vote_filter_maj_n.sv
// Combinational N-input majority and disagreement for one channel.
module maj_n #(
    parameter int N = 3
) (
    input  logic [N-1:0] bits,
    output logic         vote,
    output logic         disagree
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + CW'(bits[i]);
        end
        vote     = ones > CW'(N / 2);
        disagree = (ones != '0) && (ones != CW'(N));
    end

endmodule

// File: rtl/maj_vote_filter.sv
// Registered N-way majority voter with per-channel debounce and a saturating fault counter.
module maj_vote_filter
    import maj_vote_filter_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int W      = DEF_W,
    parameter int STABLE = DEF_STABLE,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N*W-1:0]   in_bus,
    input  logic             clr_err,
    output logic [W-1:0]     vote,
    output logic [W-1:0]     disagree,
    output logic [W-1:0]     out,
    output logic             changed,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int CNT_BITS = (STABLE > 1) ? $clog2(STABLE) : 1;

    if (N % 2 == 0 || N < 1) begin : g_bad_n
        $error("maj_vote_filter: N must be odd and >= 1");
    end
    if (STABLE < 1) begin : g_bad_stable
        $error("maj_vote_filter: STABLE must be >= 1");
    end

    logic [N-1:0]         ch_bits [W];
    logic [W-1:0]         vote_raw;
    logic [W-1:0]         dis_raw;

    logic [W-1:0]         vote_q, vote_d;
    logic [W-1:0]         disagree_q, disagree_d;
    logic                 v1_q, v1_d;
    logic [W-1:0]         out_q, out_d;
    logic                 changed_q, changed_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic [CNT_BITS-1:0]  cnt_q [W];
    logic [CNT_BITS-1:0]  cnt_d [W];

    // Regroup the replica-major bus into one N-bit slice per channel.
    always_comb begin
        for (int c = 0; c < W; c++) begin
            for (int r = 0; r < N; r++) begin
                ch_bits[c][r] = in_bus[bit_idx(r, c, W)];
            end
        end
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_chan
        maj_n #(.N(N)) u_maj (
            .bits     (ch_bits[gi]),
            .vote     (vote_raw[gi]),
            .disagree (dis_raw[gi])
        );
    end

    always_comb begin
        vote_d     = vote_q;
        disagree_d = disagree_q;
        v1_d       = en;
        out_d      = out_q;
        err_cnt_d  = err_cnt_q;
        for (int c = 0; c < W; c++) begin
            cnt_d[c] = cnt_q[c];
        end

        if (en) begin
            vote_d     = vote_raw;
            disagree_d = dis_raw;
        end

        // Debounce: only consecutive evaluations (v1 high) advance the count.
        if (v1_q) begin
            for (int c = 0; c < W; c++) begin
                if (vote_q[c] == out_q[c]) begin
                    cnt_d[c] = '0;
                end else if (cnt_q[c] == CNT_BITS'(STABLE - 1)) begin
                    out_d[c] = vote_q[c];
                    cnt_d[c] = '0;
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_BITS'(1);
                end
            end
        end

        changed_d = |(out_d ^ out_q);

        if (clr_err) begin
            err_cnt_d = '0;
        end else if (v1_q && (|disagree_q) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vote_q     <= '0;
            disagree_q <= '0;
            v1_q       <= 1'b0;
            out_q      <= '0;
            changed_q  <= 1'b0;
            err_cnt_q  <= '0;
            for (int c = 0; c < W; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            vote_q     <= vote_d;
            disagree_q <= disagree_d;
            v1_q       <= v1_d;
            out_q      <= out_d;
            changed_q  <= changed_d;
            err_cnt_q  <= err_cnt_d;
            for (int c = 0; c < W; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign vote     = vote_q;
    assign disagree = disagree_q;
    assign out      = out_q;
    assign changed  = changed_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_maj_vote_filter.sv
// Directed checks of the majority-vote filter: default build plus a 2-bit fault counter build.
module tb_maj_vote_filter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] in_bus;
    logic        clr_err;
    logic [3:0]  a_vote, a_dis, a_out;
    logic        a_changed;
    logic [7:0]  a_err;

    logic        b_en;
    logic [11:0] b_in;
    logic        b_clr;
    logic [3:0]  b_vote, b_dis, b_out;
    logic        b_changed;
    logic [1:0]  b_err;

    int total  = 0;
    int passed = 0;

    maj_vote_filter #(.N(3), .W(4), .STABLE(3), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .in_bus(in_bus), .clr_err(clr_err),
        .vote(a_vote), .disagree(a_dis), .out(a_out), .changed(a_changed), .err_cnt(a_err)
    );

    maj_vote_filter #(.N(3), .W(4), .STABLE(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .in_bus(b_in), .clr_err(b_clr),
        .vote(b_vote), .disagree(b_dis), .out(b_out), .changed(b_changed), .err_cnt(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] rep(input logic [3:0] r0, input logic [3:0] r1,
                                        input logic [3:0] r2);
        return {r2, r1, r0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in_bus = 12'hfff; clr_err = 1'b0;
        b_en = 1'b0; b_in = '0; b_clr = 1'b0;

        // Reset wins over en with all-ones input
        step(); step();
        chk("rst_vote", 32'(a_vote), 32'h0);
        chk("rst_out", 32'(a_out), 32'h0);
        chk("rst_dis", 32'(a_dis), 32'h0);
        chk("rst_err", 32'(a_err), 32'h0);
        chk("rst_changed", 32'(a_changed), 32'h0);

        // Unanimous 1010: vote after 1 cycle, out after STABLE+1
        rst = 1'b0; in_bus = rep(4'b1010, 4'b1010, 4'b1010);
        step();
        $display("txn unanimous c1 vote=%b out=%b", a_vote, a_out);
        chk("uni_vote_c1", 32'(a_vote), 32'ha);
        chk("uni_dis_c1", 32'(a_dis), 32'h0);
        chk("uni_out_c1", 32'(a_out), 32'h0);
        step();
        chk("uni_out_c2", 32'(a_out), 32'h0);
        chk("uni_chg_c2", 32'(a_changed), 32'h0);
        step();
        chk("uni_out_c3", 32'(a_out), 32'h0);
        step();
        $display("txn unanimous c4 out=%b changed=%b", a_out, a_changed);
        chk("uni_out_c4", 32'(a_out), 32'ha);
        chk("uni_chg_c4", 32'(a_changed), 32'h1);
        step();
        chk("uni_chg_c5", 32'(a_changed), 32'h0);
        chk("uni_err_c5", 32'(a_err), 32'h0);

        // Replica 2 inverted for 5 samples
        in_bus = rep(4'b1010, 4'b1010, 4'b0101);
        step();
        chk("flt_vote", 32'(a_vote), 32'ha);
        chk("flt_dis", 32'(a_dis), 32'hf);
        step(); step(); step(); step();
        chk("flt_err_4", 32'(a_err), 32'h4);
        in_bus = rep(4'b1010, 4'b1010, 4'b1010);
        step();
        $display("txn fault err_cnt=%0d dis=%b", a_err, a_dis);
        chk("flt_err_5", 32'(a_err), 32'h5);
        chk("flt_dis_clear", 32'(a_dis), 32'h0);
        step();
        chk("flt_err_hold", 32'(a_err), 32'h5);
        chk("flt_out", 32'(a_out), 32'ha);

        // Two-sample glitch is rejected
        in_bus = '0;
        step();
        chk("gl2_chg_1", 32'(a_changed), 32'h0);
        step();
        in_bus = rep(4'b1010, 4'b1010, 4'b1010);
        step();
        chk("gl2_chg_3", 32'(a_changed), 32'h0);
        step();
        chk("gl2_chg_4", 32'(a_changed), 32'h0);
        step();
        $display("txn glitch2 out=%b changed=%b", a_out, a_changed);
        chk("gl2_out", 32'(a_out), 32'ha);
        chk("gl2_chg_5", 32'(a_changed), 32'h0);

        // Three-sample run does pass through
        in_bus = '0;
        step(); step(); step();
        chk("gl3_out_pre", 32'(a_out), 32'ha);
        in_bus = rep(4'b1010, 4'b1010, 4'b1010);
        step();
        $display("txn glitch3 out=%b changed=%b", a_out, a_changed);
        chk("gl3_out", 32'(a_out), 32'h0);
        chk("gl3_chg", 32'(a_changed), 32'h1);
        step();
        chk("gl3_chg_off", 32'(a_changed), 32'h0);
        step(); step(); step();
        chk("gl3_back", 32'(a_out), 32'ha);

        // en gap holds the pending count
        in_bus = '0;
        step(); step();
        en = 1'b0;
        step(); step(); step(); step();
        chk("eng_out_hold", 32'(a_out), 32'ha);
        en = 1'b1;
        step();
        chk("eng_out_pre", 32'(a_out), 32'ha);
        step();
        $display("txn en-gap out=%b changed=%b", a_out, a_changed);
        chk("eng_out_flip", 32'(a_out), 32'h0);
        chk("eng_chg", 32'(a_changed), 32'h1);

        // Reset during PEND restarts the count
        in_bus = rep(4'b1010, 4'b1010, 4'b1010);
        step(); step(); step();
        rst = 1'b1;
        step();
        chk("rmid_out", 32'(a_out), 32'h0);
        chk("rmid_vote", 32'(a_vote), 32'h0);
        rst = 1'b0;
        step(); step();
        chk("rmid_out_e2", 32'(a_out), 32'h0);
        step();
        chk("rmid_out_e3", 32'(a_out), 32'h0);
        step();
        $display("txn rst-mid out=%b", a_out);
        chk("rmid_out_e4", 32'(a_out), 32'ha);

        // 2-bit counter saturation and clear priority
        b_en = 1'b1; b_in = rep(4'b1010, 4'b1010, 4'b0101);
        step(); step(); step(); step(); step(); step();
        $display("txn sat err_cnt=%0d", b_err);
        chk("sat_err", 32'(b_err), 32'h3);
        step();
        chk("sat_hold", 32'(b_err), 32'h3);
        b_clr = 1'b1;
        step();
        chk("clr_err", 32'(b_err), 32'h0);
        b_clr = 1'b0;
        step();
        chk("clr_resume", 32'(b_err), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/maj_vote_filter.md
Name: maj_vote_filter

Overview:
- Parametrised successor to the 3-input majority gate. Registers an N-way majority vote across W independent channels, flags replicas that disagree, and counts fault cycles in a saturating counter.
- Each channel's voted value passes through a consecutive-sample (debounce) filter before reaching the output.
- Sits between redundant (TMR-style) sources and downstream logic as a registered, glitch-rejecting voter.

Parameters:
- N, 3, replica count; must be odd and >= 1. Elaboration fails (generate error) on even N.
- W, 4, channel count per replica.
- STABLE, 3, consecutive mismatching samples needed before an output bit flips; >= 1.
- CNT_W, 8, width of the fault counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample enable; in_bus is sampled only when en = 1.
- in_bus  input  N*W  replica r, channel c sits at bit r*W+c.
- clr_err  input  1  synchronous clear of err_cnt.
- vote  output  W  registered raw majority per channel.
- disagree  output  W  registered; bit c = 1 if any replica differs from vote[c].
- out  output  W  filtered (debounced) vote.
- changed  output  1  1-cycle pulse when any out bit flips.
- err_cnt  output  CNT_W  saturating count of sampled cycles with any disagreement.

Behaviour:
- Reset values: vote, disagree, out, changed, err_cnt, all per-channel counters and the stage-1 valid flag v1 all = 0. rst has priority over every other input. rst asserted mid-count discards the pending count.
- Stage 1, on en = 1:
  - vote[c] <= (popcount of replicas' bit c) > N/2.
  - disagree[c] <= (popcount != 0) && (popcount != N).
  - v1 <= en, every cycle.
  - When en = 0, vote and disagree hold.
- Stage 2, per channel. Evaluates only when v1 = 1 and uses the registered vote.
  - States: MATCH (cnt = 0) and PEND (cnt counts mismatching evaluations).
  - If vote[c] == out[c]: cnt <= 0, go to MATCH. A glitch shorter than STABLE never reaches out.
  - Else if cnt == STABLE-1: out[c] <= vote[c], cnt <= 0, go to MATCH.
  - Else: cnt <= cnt+1, stay in or go to PEND.
  - When v1 = 0: cnt and out hold. Consecutive means consecutive evaluations, not consecutive clocks.
  - cnt width is $clog2(STABLE), minimum 1.
- changed <= 1 on a cycle where any out bit flips, else 0.
- Latency with en held high: input to vote = 1 cycle; input to out = STABLE+1 cycles. With STABLE = 1, out follows vote one cycle later.
- err_cnt:
  - On v1 = 1 and |disagree: increment, saturating at 2^CNT_W-1.
  - clr_err = 1: err_cnt <= 0. Clear wins over a simultaneous increment.
- Multiple channels flip independently in the same cycle; changed is a single OR'ed pulse.

Decomposition:
- Shared package/header holds the default localparams (N, W, STABLE, CNT_W) and the bit-index helper for replica r, channel c.
- Sub-module maj_n: combinational N-input majority plus disagree for one channel (popcount-based). It is instantiated W times by generate.
- Debounce counters and err_cnt stay in the top module.

Test Plan (N=3, W=4, STABLE=3, CNT_W=8 unless stated):
1. Reset: rst = 1 for 2 cycles with in_bus = all ones -> vote = out = disagree = 0, err_cnt = 0, changed = 0.
2. All replicas = 4'b1010, en = 1 from cycle 0 -> vote = 1010 at cycle 1, out = 1010 at cycle 4, changed = 1 only at cycle 4, disagree = 0000, err_cnt = 0.
3. Single-replica fault: r0 = r1 = 1010, r2 = 0101 for 5 cycles -> vote = 1010, disagree = 1111 from cycle 1, err_cnt = 5 after the last sample is evaluated.
4. Glitch rejection: out = 1010 settled, then all replicas = 0000 for 2 cycles, then back to 1010 -> out stays 1010, changed never pulses. Repeat with 3 cycles of 0000 -> out = 0000 with one changed pulse.
5. Saturation/clear with CNT_W = 2: 5 fault cycles -> err_cnt = 3 (held). Then clr_err = 1 while a fault is present -> err_cnt = 0 next cycle.
6. en gating and reset mid-count:
   - Mismatch for 2 evaluations, en = 0 for 4 cycles, then 1 more mismatching sample -> out flips; the count was held, not cleared.
   - Separately, rst during PEND -> out = 0, the count restarts from 0.
